rgb_sequencer: RTL and testbench
================================

Name: rgb_sequencer

Overview:
- Parametrised one-hot colour sequencer built on the colours_t encoding: RED=3'b001, GREEN=3'b010, BLUE=3'b100, plus OFF=3'b000.
- Steps through RED/GREEN/BLUE with a per-colour dwell time.
- Supports auto or manual stepping, forward or reverse order, and hold.
- Drives the LED/display colour path and gives a cycle-complete pulse to downstream logic.

Parameters:
- CNT_W, 8: dwell counter width.
- T_RED, 4: RED dwell in cycles. Legal range 1..2^CNT_W-1.
- T_GREEN, 3: GREEN dwell in cycles. Same range.
- T_BLUE, 2: BLUE dwell in cycles. Same range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = run, 0 = force OFF.
- auto  in  1  1 = dwell-timed advance, 0 = advance only on step.
- step  in  1  single-cycle advance request.
- dir  in  1  0 = R->G->B->R, 1 = R->B->G->R.
- hold  in  1  freeze colour and counter.
- color  out  3  one-hot colour, 3'b000 when OFF.
- r  out  1  equals color[0].
- g  out  1  equals color[1].
- b  out  1  equals color[2].
- cnt  out  CNT_W  cycles spent in the current colour, starting at 0.
- cycle_done  out  1  one-cycle pulse on wrap back to RED.

Behaviour:
- Reset (async assert, sync release): color=000, cnt=0, cycle_done=0, state=OFF. Reset mid-run clears immediately, with no clock needed.
- The FSM is one-hot, with state register = color. States: OFF, RED, GREEN, BLUE. Only the values 000, 001, 010 and 100 are legal. Any illegal value recovers to OFF on the next edge.
- OFF: while en=0, stay in OFF. When en=1 is sampled, go to RED at that edge with cnt=0. step and hold are ignored in OFF.
- Dwell (auto=1, hold=0): cnt increments each cycle. When cnt==T_cur-1, the next edge moves to the next colour with cnt=0. Each colour is therefore visible for exactly T_cur cycles. T=1 gives a single-cycle colour.
- Next colour when dir=0: RED->GREEN, GREEN->BLUE, BLUE->RED.
- Next colour when dir=1: RED->BLUE, BLUE->GREEN, GREEN->RED.
- dir is sampled only at the advance edge, so a change mid-dwell takes effect at the next transition.
- Manual (auto=0): cnt still increments and saturates at 2^CNT_W-1, with no wrap. A colour advances only on step=1 (hold=0), and cnt resets to 0 on the advance.
- step with auto=1 and hold=0 forces an immediate advance at that edge regardless of cnt, and cnt resets to 0.
- hold=1: colour and cnt are frozen, and step is ignored. Dwell resumes from the frozen cnt once hold=0.
- Priority, highest first: rst_n, then en=0 (go to OFF, cnt=0, cycle_done=0 at the next edge), then hold, then step, then dwell expiry.
- cycle_done is registered. It is 1 for exactly the first cycle in which color==RED after arriving from the last colour of the order (BLUE if dir=0, GREEN if dir=1). It is not asserted on entry from OFF.
- Latency: every output changes at the clock edge after the cause. r, g and b are combinational slices of the registered color.
- color is always zero- or one-hot, and r+g+b <= 1.

Test Plan:
- Reset, then en=1, auto=1, dir=0, defaults -> RED for 4 cycles (cnt 0..3), GREEN for 3 cycles, BLUE for 2 cycles, then RED. cycle_done=1 only in the first RED cycle after BLUE. Period is 9 cycles.
- dir=1 from RED -> sequence RED(4), BLUE(2), GREEN(3), RED. cycle_done fires on GREEN->RED. Toggling dir mid-BLUE changes only the next transition.
- auto=0, pulse step at cycles 5 and 12 -> RED until the step, then GREEN, then BLUE. cnt saturates at 255 when idle for 300 cycles.
- hold=1 at RED with cnt=2 for 10 cycles, with a step pulse inside the hold -> color stays 001 and cnt stays 2. After release, GREEN follows 2 cycles later.
- en=0 during GREEN with cnt=1 -> next edge color=000, cnt=0. en=1 again -> RED, and cycle_done stays 0.
- rst_n low asynchronously mid-BLUE -> color=000, cnt=0 immediately, with no clock edge. After release with en=1 -> RED on the first edge.

Source files
------------

// File: rtl/rgb_sequencer.sv
// One-hot RED/GREEN/BLUE sequencer with per-colour dwell, manual stepping,
// reversible order, hold, and a registered pulse on each wrap back to RED.
module rgb_sequencer #(
  parameter int CNT_W   = 8,
  parameter int T_RED   = 4,
  parameter int T_GREEN = 3,
  parameter int T_BLUE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             auto,
  input  logic             step,
  input  logic             dir,
  input  logic             hold,
  output logic [2:0]       color,
  output logic             r,
  output logic             g,
  output logic             b,
  output logic [CNT_W-1:0] cnt,
  output logic             cycle_done
);

  localparam logic [2:0] OFF   = 3'b000;
  localparam logic [2:0] RED   = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b100;

  localparam logic [CNT_W-1:0] LAST_RED   = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] LAST_GREEN = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LAST_BLUE  = CNT_W'(T_BLUE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [2:0]       color_q, color_d, nxt_col;
  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic             done_q, done_d;
  logic             legal, advance;

  // Successor colour and final dwell count of the current colour.
  always_comb begin
    nxt_col = OFF;
    last    = '0;
    legal   = 1'b1;
    case (color_q)
      OFF:   nxt_col = RED;
      RED:   begin nxt_col = dir ? BLUE  : GREEN; last = LAST_RED;   end
      GREEN: begin nxt_col = dir ? RED   : BLUE;  last = LAST_GREEN; end
      BLUE:  begin nxt_col = dir ? GREEN : RED;   last = LAST_BLUE;  end
      default: legal = 1'b0;
    endcase
  end

  // '>=' rather than '==' lets a count left high by manual mode expire at once
  // when auto is re-enabled; in pure auto operation the two are identical.
  assign advance = step || (auto && (cnt_q >= last));

  always_comb begin
    color_d = color_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!legal || !en) begin
      color_d = OFF;
      cnt_d   = '0;
    end else if (color_q == OFF) begin
      color_d = RED;
      cnt_d   = '0;
    end else if (hold) begin
      color_d = color_q;
      cnt_d   = cnt_q;
    end else if (advance) begin
      color_d = nxt_col;
      cnt_d   = '0;
      done_d  = (nxt_col == RED);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_q <= OFF;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      color_q <= color_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign color      = color_q;
  assign r          = color_q[0];
  assign g          = color_q[1];
  assign b          = color_q[2];
  assign cnt        = cnt_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Directed, table-driven bench for rgb_sequencer with default parameters.
module tb_rgb_sequencer;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, auto = 1'b0, step = 1'b0, dir = 1'b0, hold = 1'b0;
  logic [2:0]    color;
  logic          r, g, b, cycle_done;
  logic [CW-1:0] cnt;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] O = 3'b000, R = 3'b001, G = 3'b010, B = 3'b100;

  typedef struct {
    logic        en, au, st, di, ho;
    logic [2:0]  col;
    int unsigned cnt;
    logic        done;
  } vec_t;

  vec_t tab[$];

  rgb_sequencer #(.CNT_W(CW), .T_RED(4), .T_GREEN(3), .T_BLUE(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .step(step), .dir(dir),
    .hold(hold), .color(color), .r(r), .g(g), .b(b), .cnt(cnt),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic a, logic s, logic d, logic h,
                              logic [2:0] c, int unsigned n, logic dn);
    vec_t v;
    v.en = e; v.au = a; v.st = s; v.di = d; v.ho = h;
    v.col = c; v.cnt = n; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input int idx, input logic [2:0] c,
                           input int unsigned n, input logic dn);
    chk({nm, ".color"}, idx, 32'(color), 32'(c));
    chk({nm, ".rgb"},   idx, 32'({b, g, r}), 32'(c));
    chk({nm, ".cnt"},   idx, 32'(cnt), n);
    chk({nm, ".done"},  idx, 32'(cycle_done), 32'(dn));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tab.size(); i++) begin
      en = tab[i].en; auto = tab[i].au; step = tab[i].st;
      dir = tab[i].di; hold = tab[i].ho;
      tick();
      chk_state(nm, i, tab[i].col, tab[i].cnt, tab[i].done);
    end
    tab.delete();
  endtask

  task automatic do_reset();
    en = 0; auto = 0; step = 0; dir = 0; hold = 0;
    rst_n = 1'b0;
    repeat (2) tick();
    chk_state("reset", 0, O, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Auto dwell forward, then reverse, then dir toggle inside BLUE.
    do_reset();
    tab.push_back(mk(1,1,0,0,0, R,0,0));
    tab.push_back(mk(1,1,0,0,0, R,1,0));
    tab.push_back(mk(1,1,0,0,0, R,2,0));
    tab.push_back(mk(1,1,0,0,0, R,3,0));
    tab.push_back(mk(1,1,0,0,0, G,0,0));
    tab.push_back(mk(1,1,0,0,0, G,1,0));
    tab.push_back(mk(1,1,0,0,0, G,2,0));
    tab.push_back(mk(1,1,0,0,0, B,0,0));
    tab.push_back(mk(1,1,0,0,0, B,1,0));
    tab.push_back(mk(1,1,0,0,0, R,0,1));
    tab.push_back(mk(1,1,0,0,0, R,1,0));
    tab.push_back(mk(1,1,0,1,0, R,2,0));
    tab.push_back(mk(1,1,0,1,0, R,3,0));
    tab.push_back(mk(1,1,0,1,0, B,0,0));
    tab.push_back(mk(1,1,0,1,0, B,1,0));
    tab.push_back(mk(1,1,0,1,0, G,0,0));
    tab.push_back(mk(1,1,0,1,0, G,1,0));
    tab.push_back(mk(1,1,0,1,0, G,2,0));
    tab.push_back(mk(1,1,0,1,0, R,0,1));
    tab.push_back(mk(1,1,0,1,0, R,1,0));
    tab.push_back(mk(1,1,0,1,0, R,2,0));
    tab.push_back(mk(1,1,0,1,0, R,3,0));
    tab.push_back(mk(1,1,0,1,0, B,0,0));
    tab.push_back(mk(1,1,0,0,0, B,1,0));
    tab.push_back(mk(1,1,0,0,0, R,0,1));
    tab.push_back(mk(1,1,0,0,0, R,1,0));
    run_table("auto");

    // Manual stepping and counter saturation.
    do_reset();
    tab.push_back(mk(1,0,0,0,0, R,0,0));
    tab.push_back(mk(1,0,0,0,0, R,1,0));
    tab.push_back(mk(1,0,0,0,0, R,2,0));
    tab.push_back(mk(1,0,0,0,0, R,3,0));
    tab.push_back(mk(1,0,1,0,0, G,0,0));
    for (int unsigned k = 1; k <= 6; k++) tab.push_back(mk(1,0,0,0,0, G,k,0));
    tab.push_back(mk(1,0,1,0,0, B,0,0));
    tab.push_back(mk(1,0,0,0,0, B,1,0));
    run_table("manual");
    repeat (253) tick();
    chk_state("sat", 0, B, 254, 0);
    tick();
    chk_state("sat", 1, B, 255, 0);
    repeat (50) tick();
    chk_state("sat", 2, B, 255, 0);

    // Hold with a step inside it, en drop during GREEN, OFF ignores step/hold.
    do_reset();
    tab.push_back(mk(1,1,0,0,0, R,0,0));
    tab.push_back(mk(1,1,0,0,0, R,1,0));
    tab.push_back(mk(1,1,0,0,0, R,2,0));
    for (int k = 0; k < 10; k++) tab.push_back(mk(1,1,(k == 4),0,1, R,2,0));
    tab.push_back(mk(1,1,0,0,0, R,3,0));
    tab.push_back(mk(1,1,0,0,0, G,0,0));
    tab.push_back(mk(1,1,0,0,0, G,1,0));
    tab.push_back(mk(0,1,0,0,0, O,0,0));
    tab.push_back(mk(0,1,1,0,1, O,0,0));
    tab.push_back(mk(1,1,0,0,1, R,0,0));
    tab.push_back(mk(1,1,0,0,0, R,1,0));
    tab.push_back(mk(1,1,1,0,0, G,0,0));
    tab.push_back(mk(1,1,0,0,0, G,1,0));
    tab.push_back(mk(1,1,0,0,0, G,2,0));
    tab.push_back(mk(1,1,0,0,0, B,0,0));
    run_table("hold_en");

    // Asynchronous reset mid-BLUE, well clear of any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 0, O, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1; auto = 1;
    tick();
    chk_state("post_rst", 0, R, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
